// File: rtl/block_encode_pkg.sv
// Shared definitions for the 2x4 block encoder and its matching decoders:
// mode codes, word field positions and default frame geometry.
package block_encode_pkg;

  localparam int BLK_COLS_DEF = 180;
  localparam int BLK_ROWS_DEF = 780;

  typedef enum logic [1:0] {
    MODE_SP   = 2'b00,
    MODE_IC   = 2'b01,
    MODE_SP2  = 2'b10,
    MODE_HPTC = 2'b11
  } mode_e;

  // Encoded word layout (64 bits, header in the two MSBs)
  localparam int HDR_LSB     = 62;
  localparam int HDR_W       = 2;
  localparam int COLOR_A_LSB = 38;
  localparam int COLOR_B_LSB = 14;
  localparam int COLOR_W     = 24;
  localparam int IC_MAP_LSB  = 6;
  localparam int HPTC_MSB    = 61;
  localparam int HPTC_W      = 6;
  localparam int SP2_MSB     = 61;
  localparam int SP2_W       = 7;

endpackage

// File: rtl/blk_mode_pack.sv
// Combinational mode classification and packing of one 2x4 RGB888 block.
// pix[0..3] is the top row left to right, pix[4..7] the bottom row.
module blk_mode_pack
  import block_encode_pkg::*;
(
  input  logic [7:0][23:0] pix,
  output mode_e            mode,
  output logic [63:0]      word
);

  logic        all_eq;
  logic        found;
  logic        two_col;
  logic        gray;
  logic [23:0] color_b;

  always_comb begin
    all_eq  = 1'b1;
    found   = 1'b0;
    color_b = pix[0];
    for (int k = 1; k < 8; k++) begin
      if (pix[k] != pix[0]) begin
        all_eq = 1'b0;
        if (!found) begin
          found   = 1'b1;
          color_b = pix[k];
        end
      end
    end
    // Exactly two colours: every pixel is either A or the first differing colour
    two_col = ~all_eq;
    gray    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if ((pix[k] != pix[0]) && (pix[k] != color_b)) two_col = 1'b0;
      if ((pix[k][23:16] != pix[k][15:8]) || (pix[k][15:8] != pix[k][7:0])) gray = 1'b0;
    end
  end

  always_comb begin
    mode = MODE_SP2;
    if (all_eq)       mode = MODE_SP;
    else if (two_col) mode = MODE_IC;
    else if (gray)    mode = MODE_HPTC;
  end

  always_comb begin
    word = '0;
    unique case (mode)
      MODE_SP: word[COLOR_A_LSB +: COLOR_W] = pix[0];
      MODE_IC: begin
        word[COLOR_A_LSB +: COLOR_W] = pix[0];
        word[COLOR_B_LSB +: COLOR_W] = color_b;
        for (int k = 0; k < 8; k++) word[IC_MAP_LSB + k] = (pix[k] == color_b);
      end
      MODE_HPTC: begin
        for (int k = 0; k < 8; k++) word[HPTC_MSB - HPTC_W*k -: HPTC_W] = pix[k][23:18];
      end
      default: begin
        for (int k = 0; k < 8; k++)
          word[SP2_MSB - SP2_W*k -: SP2_W] = {pix[k][23:22], pix[k][15:13], pix[k][7:6]};
      end
    endcase
    word[HDR_LSB +: HDR_W] = mode;
  end

endmodule

// File: rtl/block_encode_top.sv
// Two-stage block encoder: S1 holds the pixels and position tag, S2 holds the
// packed word and its frame flags. out_mode mirrors the S2 header for checkers.
module block_encode_top
  import block_encode_pkg::*;
#(
  parameter int BLK_COLS = BLK_COLS_DEF,
  parameter int BLK_ROWS = BLK_ROWS_DEF
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sof,
  input  logic [23:0] pixel0,
  input  logic [23:0] pixel1,
  input  logic [23:0] pixel2,
  input  logic [23:0] pixel3,
  input  logic [23:0] pixel4,
  input  logic [23:0] pixel5,
  input  logic [23:0] pixel6,
  input  logic [23:0] pixel7,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_eof,
  output mode_e       out_mode
);

  localparam int CW = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;
  localparam int RW = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(BLK_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(BLK_ROWS - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and a stalled word (valid & ~ready) holds.
  logic             s1_valid, s2_valid;
  logic [7:0][23:0] s1_pix;
  logic             s1_sof, s1_eol, s1_eof;
  logic             s2_load, accept;
  logic [CW-1:0]    col, tag_col;
  logic [RW-1:0]    row, tag_row;
  mode_e            pack_mode;
  logic [63:0]      pack_word;

  assign s2_load   = ~s2_valid | out_ready;
  assign in_ready  = ~s1_valid | s2_load;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  // in_sof forces the tag to (0,0); the counters then advance from the tag
  assign tag_col = in_sof ? '0 : col;
  assign tag_row = in_sof ? '0 : row;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (tag_col == COL_LAST) begin
        col <= '0;
        row <= (tag_row == ROW_LAST) ? '0 : tag_row + 1'b1;
      end else begin
        col <= tag_col + 1'b1;
        row <= tag_row;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pix <= {pixel7, pixel6, pixel5, pixel4, pixel3, pixel2, pixel1, pixel0};
        s1_sof <= (tag_col == '0) && (tag_row == '0);
        s1_eol <= (tag_col == COL_LAST);
        s1_eof <= (tag_col == COL_LAST) && (tag_row == ROW_LAST);
      end
    end
  end

  blk_mode_pack u_pack (
    .pix  (s1_pix),
    .mode (pack_mode),
    .word (pack_word)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_mode <= MODE_SP;
      out_sof  <= 1'b0;
      out_eol  <= 1'b0;
      out_eof  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= pack_word;
        out_mode <= pack_mode;
        out_sof  <= s1_sof;
        out_eol  <= s1_eol;
        out_eof  <= s1_eof;
      end
    end
  end

endmodule

// File: tb/tb_block_encode_top.sv
// Randomized scoreboard bench for block_encode_top on a 4x3 block frame; the
// reference model classifies blocks by counting distinct colours.
module tb_block_encode_top;
  import block_encode_pkg::*;

  localparam int C = 4;
  localparam int R = 3;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sof;
  logic [23:0] pixel0, pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic        out_sof, out_eol, out_eof;
  mode_e       out_mode;

  block_encode_top #(.BLK_COLS(C), .BLK_ROWS(R)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .pixel0(pixel0), .pixel1(pixel1), .pixel2(pixel2), .pixel3(pixel3),
    .pixel4(pixel4), .pixel5(pixel5), .pixel6(pixel6), .pixel7(pixel7),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .out_mode(out_mode)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [66:0] exp_q[$];   // {sof, eol, eof, word}
  int          blk_n = 0;  // linear block index within the frame
  logic        bp_on = 1'b0;
  logic        rdy_lvl = 1'b1;

  task automatic chk(input string name, input logic [66:0] got, input logic [66:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_word(input logic [7:0][23:0] p);
    logic [23:0] cl[$];
    logic        gray;
    logic [7:0]  map;
    logic [47:0] g;
    logic [55:0] s;
    gray = 1'b1;
    g = '0;
    s = '0;
    for (int k = 0; k < 8; k++) begin
      bit seen;
      seen = 0;
      foreach (cl[j]) if (cl[j] == p[k]) seen = 1;
      if (!seen) cl.push_back(p[k]);
      if (!(p[k][23:16] == p[k][15:8] && p[k][15:8] == p[k][7:0])) gray = 1'b0;
      g = {g[41:0], p[k][23:18]};
      s = {s[48:0], p[k][23:22], p[k][15:13], p[k][7:6]};
    end
    if (cl.size() == 1) return {2'b00, p[0], 38'b0};
    if (cl.size() == 2) begin
      for (int k = 0; k < 8; k++) map[k] = (p[k] == cl[1]);
      return {2'b01, p[0], cl[1], map, 6'b0};
    end
    if (gray) return {2'b11, g, 14'b0};
    return {2'b10, s, 6'b0};
  endfunction

  task automatic push_exp(input logic [7:0][23:0] p, input logic sof,
                          input logic use_lit, input logic [63:0] lit);
    int c, r;
    if (sof) blk_n = 0;
    c = blk_n % C;
    r = blk_n / C;
    exp_q.push_back({(c == 0 && r == 0), (c == C-1), (c == C-1 && r == R-1),
                     use_lit ? lit : ref_word(p)});
    blk_n = (blk_n + 1) % (C * R);
  endtask

  // ---------------- drivers ----------------
  task automatic send_block(input logic [7:0][23:0] p, input logic sof,
                            input logic use_lit, input logic [63:0] lit);
    int budget;
    @(negedge clk_in);
    in_valid = 1'b1;
    in_sof   = sof;
    {pixel7, pixel6, pixel5, pixel4, pixel3, pixel2, pixel1, pixel0} = p;
    budget = 0;
    #1;
    while (!in_ready && budget < 200) begin
      @(negedge clk_in);
      #1;
      budget++;
    end
    if (!in_ready) chk("accept_timeout", {66'b0, in_ready}, 67'd1);
    else push_exp(p, sof, use_lit, lit);
    @(posedge clk_in);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic gen_pix(output logic [7:0][23:0] p);
    logic [23:0] a, b;
    logic [7:0]  y;
    a = 24'($urandom);
    b = 24'($urandom);
    if (a == b) b = a ^ 24'h1;
    case ($urandom_range(0, 3))
      0: for (int k = 0; k < 8; k++) p[k] = a;
      1: begin
        for (int k = 0; k < 8; k++) p[k] = ($urandom_range(0, 1) == 1) ? b : a;
        p[0] = a;
        p[$urandom_range(1, 7)] = b;
      end
      2: for (int k = 0; k < 8; k++) begin
        y = 8'($urandom);
        p[k] = {y, y, y};
      end
      default: for (int k = 0; k < 8; k++) p[k] = 24'($urandom);
    endcase
  endtask

  task automatic send_rand(input logic sof);
    logic [7:0][23:0] p;
    gen_pix(p);
    send_block(p, sof, 1'b0, 64'h0);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(negedge clk_in);
      budget++;
    end
    chk("drain_timeout", 67'(exp_q.size()), 67'd0);
  endtask

  // ---------------- out_ready pattern ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk_in);
      out_ready = bp_on ? ($urandom_range(0, 1) == 1) : rdy_lvl;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        hold_chk = 1'b0;
  logic [66:0] held, got, e;

  initial begin
    forever begin
      @(negedge clk_in);
      #2;
      if (!rst_n) hold_chk = 1'b0;
      else begin
        got = {out_sof, out_eol, out_eof, out_data};
        if (hold_chk) chk("stall_hold", {got[65:0], out_valid}, {held[65:0], 1'b1});
        if (hold_chk) chk("stall_hold_sof", {66'b0, got[66]}, {66'b0, held[66]});
        hold_chk = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_word", got, 67'h0 ^ ~got);
          else begin
            e = exp_q.pop_front();
            chk("word", got, e);
            chk("mode", 67'(out_mode), 67'(e[63:62]));
          end
        end else if (out_valid) begin
          hold_chk = 1'b1;
          held     = got;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0][23:0] p;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    {pixel7, pixel6, pixel5, pixel4, pixel3, pixel2, pixel1, pixel0} = '0;
    repeat (3) @(negedge clk_in);
    #1;
    chk("rst_out_valid", {66'b0, out_valid}, 67'd0);
    chk("rst_out_data", {3'b0, out_data}, 67'd0);
    chk("rst_flags", {64'b0, out_sof, out_eol, out_eof}, 67'd0);
    chk("rst_in_ready", {66'b0, in_ready}, 67'd1);
    @(negedge clk_in);
    rst_n = 1'b1;

    // directed: uniform, two-colour, gray ramp, distinct non-gray
    for (int k = 0; k < 8; k++) p[k] = 24'h123456;
    send_block(p, 1'b1, 1'b1, 64'h048D_1580_0000_0000);
    for (int k = 0; k < 8; k++) p[k] = (k < 4) ? 24'hFF0000 : 24'h00FF00;
    send_block(p, 1'b0, 1'b1, {2'b01, 24'hFF0000, 24'h00FF00, 8'hF0, 6'b0});
    for (int k = 0; k < 8; k++) p[k] = {3{8'(8'h20 * k)}};
    send_block(p, 1'b0, 1'b1, {2'b11, 6'd0, 6'd8, 6'd16, 6'd24, 6'd32, 6'd40, 6'd48, 6'd56, 14'b0});
    for (int k = 0; k < 8; k++) p[k] = 24'h102030 + 24'(24'h010203 * k);
    send_block(p, 1'b0, 1'b0, 64'h0);

    // rest of frame 1 plus all of frame 2 (wrap gives sof on word 13)
    for (int i = 0; i < 20; i++) send_rand(1'b0);
    drain();

    // random backpressure with input gaps
    bp_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_rand(1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
    end
    for (int i = 0; i < 16; i++) send_rand(1'b0);
    drain();
    bp_on = 1'b0;

    // mid-frame restart on block 5
    for (int i = 0; i < 9; i++) send_rand(i == 4);
    drain();

    // reset with blocks in flight, then first block must be tagged (0,0)
    rdy_lvl = 1'b0;
    send_rand(1'b0);
    send_rand(1'b0);
    @(negedge clk_in);
    rst_n = 1'b0;
    exp_q.delete();
    blk_n = 0;
    #1;
    chk("midrst_out_valid", {66'b0, out_valid}, 67'd0);
    chk("midrst_in_ready", {66'b0, in_ready}, 67'd1);
    @(negedge clk_in);
    rst_n = 1'b1;
    rdy_lvl = 1'b1;
    send_rand(1'b0);
    send_rand(1'b0);
    drain();

    repeat (3) @(negedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
